// File: rtl/dec_syndrome_if.sv
// dec_syndrome_if: request/result bundle between the codeword source and the
// syndrome stage.
//   master: drives start, mode and DATA_IN. Receives busy, done, S, NOF,
//           Small, Medium and DATA_OUT.
//   slave : the syndrome stage itself (the opposite directions).
interface dec_syndrome_if #(
  parameter int AMBA_WORD = 32
);
  logic                 start;
  logic [1:0]           mode;
  logic [AMBA_WORD-1:0] DATA_IN;
  logic                 busy;
  logic                 done;
  logic [4:0]           S;
  logic [1:0]           NOF;
  logic                 Small;
  logic                 Medium;
  logic [AMBA_WORD-1:0] DATA_OUT;

  modport master (
    output start, mode, DATA_IN,
    input  busy, done, S, NOF, Small, Medium, DATA_OUT
  );

  modport slave (
    input  start, mode, DATA_IN,
    output busy, done, S, NOF, Small, Medium, DATA_OUT
  );
endinterface

// File: rtl/dec_syndrome.sv
// dec_syndrome: SECDED syndrome generation ahead of the single-error
// correction stage. Each accepted codeword (8, 16 or 32 bits) is folded one
// byte per clock into a syndrome/overall-parity accumulator. S, NOF, Small,
// Medium and the masked codeword are then published together with a done
// pulse, and they hold until the next done.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - dec_syndrome_if.slave: start/mode/DATA_IN request, busy/done
//          status, and the S/NOF/Small/Medium/DATA_OUT results
module dec_syndrome #(
  parameter int AMBA_WORD = 32
) (
  input  logic           clk,
  input  logic           rst,
  dec_syndrome_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]           state;
  logic [1:0]           beat;
  logic [1:0]           mode_r;
  logic [AMBA_WORD-1:0] data_r;
  logic [4:0]           acc_s;
  logic                 acc_p;

  logic                 done_r;
  logic [4:0]           s_r;
  logic [1:0]           nof_r;
  logic                 small_r;
  logic                 medium_r;
  logic [AMBA_WORD-1:0] dout_r;

  logic [2:0]           m_w;
  logic [1:0]           last_beat;
  logic [4:0]           idx;
  logic [4:0]           fold_s;
  logic                 fold_p;

  // Keeps only the bits that belong to a codeword of the given size.
  function automatic logic [AMBA_WORD-1:0] size_mask(input logic [1:0] md);
    logic [AMBA_WORD-1:0] mk;
    case (md)
      2'b00:   mk = AMBA_WORD'(32'h0000_00FF);
      2'b01:   mk = AMBA_WORD'(32'h0000_FFFF);
      default: mk = '1;
    endcase
    return mk;
  endfunction

  // Parity-check column for bit position idx in a code with m syndrome bits.
  // Data columns are the values with two or more ones, in ascending order.
  // That sequence does not depend on m, so one scan serves all three sizes.
  function automatic logic [4:0] col_h(input logic [2:0] m, input logic [4:0] pos);
    logic [4:0] h;
    int         k;
    int         cnt;
    h   = '0;
    k   = 0;
    cnt = 0;
    if ({2'b00, m} > pos) begin
      h = 5'd1 << pos;
    end else if ({2'b00, m} < pos) begin
      k = int'(pos) - int'(m) - 1;
      for (int v = 3; v < 32; v++) begin
        if ($countones(5'(v)) >= 2) begin
          if (cnt == k) h = 5'(v);
          cnt++;
        end
      end
    end
    return h;
  endfunction

  // A set overall-parity bit marks a single error, even when the syndrome is
  // zero: in that case the flipped bit is the parity bit itself.
  function automatic logic [1:0] nof_of(input logic [4:0] s, input logic p);
    logic [1:0] n;
    if (p)              n = 2'b01;
    else if (s != 5'd0) n = 2'b10;
    else                n = 2'b00;
    return n;
  endfunction

  always_comb begin
    case (mode_r)
      2'b00:   begin m_w = 3'd3; last_beat = 2'd0; end
      2'b01:   begin m_w = 3'd4; last_beat = 2'd1; end
      default: begin m_w = 3'd5; last_beat = 2'd3; end
    endcase
  end

  // Fold the current byte into the running syndrome and parity. Bits above
  // the codeword width were cleared at capture, so their columns never
  // contribute.
  always_comb begin
    idx    = '0;
    fold_s = acc_s;
    fold_p = acc_p;
    for (int j = 0; j < 8; j++) begin
      idx = {beat, 3'(j)};
      if (data_r[idx]) begin
        fold_s = fold_s ^ col_h(m_w, idx);
        fold_p = ~fold_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      mode_r   <= '0;
      data_r   <= '0;
      acc_s    <= '0;
      acc_p    <= 1'b0;
      done_r   <= 1'b0;
      s_r      <= '0;
      nof_r    <= '0;
      small_r  <= 1'b0;
      medium_r <= 1'b0;
      dout_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_r <= bus.DATA_IN & size_mask(bus.mode);
            mode_r <= bus.mode;
            acc_s  <= '0;
            acc_p  <= 1'b0;
            beat   <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (beat == last_beat) begin
            s_r      <= fold_s;
            nof_r    <= nof_of(fold_s, fold_p);
            small_r  <= (mode_r == 2'b00);
            medium_r <= (mode_r == 2'b01);
            dout_r   <= data_r;
            done_r   <= 1'b1;
            beat     <= '0;
            state    <= IDLE;
          end else begin
            acc_s <= fold_s;
            acc_p <= fold_p;
            beat  <= beat + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == CALC);
  assign bus.done     = done_r;
  assign bus.S        = s_r;
  assign bus.NOF      = nof_r;
  assign bus.Small    = small_r;
  assign bus.Medium   = medium_r;
  assign bus.DATA_OUT = dout_r;

endmodule

// File: tb/tb_dec_syndrome.sv
// tb_dec_syndrome: directed bench for dec_syndrome. Expected results are
// queued when a start is driven and compared when done appears.
module tb_dec_syndrome;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [4:0]  s;
    logic [1:0]  nof;
    logic        sm;
    logic        md;
    logic [31:0] dout;
    int          cyc;
  } exp_t;

  exp_t q[$];

  dec_syndrome_if #(.AMBA_WORD(32)) bus ();

  dec_syndrome #(.AMBA_WORD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic send(input logic [1:0] md, input logic [31:0] d,
                      input logic [4:0] s, input logic [1:0] nof);
    exp_t e;
    logic [31:0] mk;
    int nb;
    case (md)
      2'b00:   begin mk = 32'h0000_00FF; nb = 1; end
      2'b01:   begin mk = 32'h0000_FFFF; nb = 2; end
      default: begin mk = 32'hFFFF_FFFF; nb = 4; end
    endcase
    e.s    = s;
    e.nof  = nof;
    e.sm   = (md == 2'b00);
    e.md   = (md == 2'b01);
    e.dout = d & mk;
    e.cyc  = cyc + nb + 1;
    q.push_back(e);
    bus.start   = 1'b1;
    bus.mode    = md;
    bus.DATA_IN = d;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.mode    = 2'($urandom);
    bus.DATA_IN = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_S"}, bus.S, 0);
    chk({tag, "_NOF"}, bus.NOF, 0);
    chk({tag, "_Small"}, bus.Small, 0);
    chk({tag, "_Medium"}, bus.Medium, 0);
    chk({tag, "_DATA_OUT"}, bus.DATA_OUT, 0);
  endtask

  // Scoreboard side: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", bus.done, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", bus.busy, 0);
        chk("S", bus.S, e.s);
        chk("NOF", bus.NOF, e.nof);
        chk("Small", bus.Small, e.sm);
        chk("Medium", bus.Medium, e.md);
        chk("DATA_OUT", bus.DATA_OUT, e.dout);
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = 2'b10;
    bus.DATA_IN = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Large patterns
    send(2'b10, 32'h0000_0000, 5'b00000, 2'b00); drain(); @(negedge clk);
    send(2'b10, 32'h0000_0063, 5'b00000, 2'b00); drain(); @(negedge clk);
    send(2'b10, 32'h0000_0040, 5'b00011, 2'b01); drain(); @(negedge clk);
    send(2'b10, 32'h0000_0020, 5'b00000, 2'b01); drain(); @(negedge clk);
    send(2'b10, 32'h8000_0000, 5'b11111, 2'b01); drain(); @(negedge clk);
    send(2'b10, 32'h0000_0003, 5'b00011, 2'b10); drain(); @(negedge clk);
    // mode 11 behaves as large
    send(2'b11, 32'h0000_0040, 5'b00011, 2'b01); drain(); @(negedge clk);

    // Small and medium, with junk above the codeword width
    send(2'b00, 32'hFFFF_FF10, 5'b00011, 2'b01); drain(); @(negedge clk);
    send(2'b01, 32'h0000_8000, 5'b01111, 2'b01); drain(); @(negedge clk);
    send(2'b01, 32'hABCD_8000, 5'b01111, 2'b01); drain();

    // Results hold between transactions
    repeat (3) @(negedge clk);
    chk("hold_done", bus.done, 0);
    chk("hold_S", bus.S, 5'b01111);
    chk("hold_NOF", bus.NOF, 2'b01);
    chk("hold_Medium", bus.Medium, 1);
    chk("hold_DATA_OUT", bus.DATA_OUT, 32'h0000_8000);

    // start while busy is ignored (one done only)
    send(2'b10, 32'h0000_0040, 5'b00011, 2'b01);
    chk("busy_cycle1", bus.busy, 1);
    bus.start   = 1'b1;
    bus.mode    = 2'b10;
    bus.DATA_IN = 32'h0000_0003;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Reset in cycle 3 aborts the transaction
    send(2'b10, 32'h8000_0000, 5'b11111, 2'b01);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midreset");
    q.delete();
    repeat (8) @(negedge clk);
    chk("midreset_later_S", bus.S, 0);

    // Back-to-back: new start during the done cycle
    send(2'b10, 32'h0000_0040, 5'b00011, 2'b01);
    repeat (4) @(negedge clk);
    chk("b2b_done_cycle", bus.done, 1);
    chk("b2b_busy", bus.busy, 0);
    send(2'b00, 32'h0000_0010, 5'b00011, 2'b01);
    drain();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dec_syndrome.md
# dec_syndrome

Syndrome-generation stage of the decoder datapath. It sits directly upstream of the single-error correction stage. It accepts one received SECDED codeword per transaction (8, 16 or 32 bits) and accumulates the parity-check syndrome and overall parity serially, one byte per clock. It then presents S, NOF, Small, Medium and the masked codeword together, in the form the correction stage consumes.

## Interface
- AMBA_WORD, 32, codeword/data path width; only 32 is supported.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request pulse; sampled only when busy=0.
- mode  in  2  codeword size: 00 small (8b), 01 medium (16b), 10 large (32b), 11 treated as large.
- DATA_IN  in  AMBA_WORD  received codeword; sampled with start.
- busy  out  1  high while beats are being processed.
- done  out  1  one-cycle pulse: outputs below updated this cycle.
- S  out  5  syndrome, zero-extended to 5 bits.
- NOF  out  2  error class: 00 none, 01 single (correctable), 10 double.
- Small  out  1  result belongs to a small codeword.
- Medium  out  1  result belongs to a medium codeword.
- DATA_OUT  out  AMBA_WORD  captured codeword with bits above the mode width forced to 0.

## Operation
- Syndrome width m: small 3, medium 4, large 5. Codeword width n = 2^m.
- Codeword layout:
  - bits[m-1:0] are parity bits P0..P(m-1).
  - bit m is the overall parity bit.
  - bits[n-1:m+1] are data bits d0..d(n-m-2).
- Column vectors h(i):
  - Parity bit Pj: h = one-hot (1<<j).
  - Overall parity bit: h = 0.
  - Data bit dk: h = the k-th value, ascending order, among m-bit values with at least two ones. Large mode: d0=00011, d1=00101, d2=00110, d3=00111, d4=01001, …, d25=11111.
- Syndrome: S = XOR of h(i) over all set bits i < n. Bits of S at and above m are 0.
- Overall parity: P = XOR of codeword bits [n-1:0].
- NOF derivation:
  - S=0 and P=0: NOF=00.
  - P=1: NOF=01. This includes S=0, which indicates an error in the overall parity bit.
  - S≠0 and P=0: NOF=10.
  - NOF=11 is never produced.
- FSM states and transitions:
  - IDLE: on start, capture the masked DATA_IN and mode, clear the S/P accumulators, and go to CALC with beat=0.
  - CALC: beat b folds bits [8b+7:8b] into the accumulators. Beat count N is 1 (small), 2 (medium) or 4 (large).
    - Not the last beat: beat increments and the FSM stays in CALC.
    - Last beat: register S, NOF, Small, Medium and DATA_OUT, assert done, and return to IDLE.
- Hold behaviour: S, NOF, Small, Medium and DATA_OUT hold their values until the next done. Between transactions the correction stage sees stable values.
- Small = (mode==00). Medium = (mode==01). Both are registered at done, together with S and NOF.

## Timing
- Reset: state=IDLE, beat=0, accumulators 0. All outputs are 0: busy, done, S, NOF, Small, Medium, DATA_OUT.
- Reset mid-transaction: the transaction is aborted, no done is produced, and outputs return to 0 on the next edge.
- Start accepted in cycle 0:
  - busy=1 in cycles 1..N.
  - done=1 and the new outputs appear in cycle N+1; busy=0 in that cycle.
  - Latency from start to done is 2 cycles (small), 3 (medium) and 5 (large).
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted. done still falls the following cycle.
- start while busy=1 is ignored; it is not queued.
- DATA_IN and mode are don't-care outside the start cycle.
- Bits of DATA_IN at and above n never affect S, NOF or DATA_OUT.

## Test plan
- Large, DATA_IN=0x00000000 -> done in cycle 5: S=00000, NOF=00, Small=0, Medium=0, DATA_OUT=0.
- Large, valid codeword 0x00000063 (d0 set; P0, P1 and overall parity set) -> S=00000, NOF=00.
- Large single errors:
  - 0x00000040 -> S=00011, NOF=01.
  - 0x00000020 -> S=00000, NOF=01.
  - 0x80000000 -> S=11111, NOF=01.
- Large double error 0x00000003 -> S=00011, NOF=10.
- Small, DATA_IN=0xFFFFFF10 -> done in cycle 2: S=00011, NOF=01, Small=1, DATA_OUT=0x00000010.
- Medium, DATA_IN=0x00008000 -> done in cycle 3: S=01111, NOF=01, Medium=1.
- Large start, then start again in cycle 2 -> the second start is ignored and exactly one done occurs, in cycle 5.
- Large start, then rst in cycle 3 -> no done and all outputs are 0 from cycle 4.
- A new start asserted in the done cycle is accepted and produces its own done.
